// File: rtl/ram_loader.sv
// Boot-time RAM loader: streams bytes into a single-port RAM from address 0, then
// optionally reads the region back and compares a mod-2^DATA_WIDTH checksum.
module ram_loader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int VERIFY     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ram_read_en,
    output logic                  ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_DRAIN,
        S_COMPARE,
        S_FINISH
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH:0]   len_reg, len_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [ADDR_WIDTH-1:0] raddr_reg, raddr_next;
    logic [DATA_WIDTH-1:0] wsum_reg, wsum_next;
    logic [DATA_WIDTH-1:0] rsum_reg, rsum_next;
    logic                  rd_pending_reg, rd_pending_next;
    logic                  error_reg, error_next;
    logic                  done_reg, done_next;

    logic [ADDR_WIDTH:0]   last_idx;
    logic [ADDR_WIDTH:0]   len_clamped;
    logic                  last_wr;
    logic                  last_rd;

    assign last_idx    = len_reg - ONE_L;
    assign len_clamped = (length > DEPTH_L) ? DEPTH_L : length;
    // Address counters stop at len-1 rather than incrementing, so a full-depth load never wraps.
    assign last_wr     = ({1'b0, addr_reg} == last_idx);
    assign last_rd     = ({1'b0, raddr_reg} == last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            len_reg        <= '0;
            addr_reg       <= '0;
            raddr_reg      <= '0;
            wsum_reg       <= '0;
            rsum_reg       <= '0;
            rd_pending_reg <= 1'b0;
            error_reg      <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            len_reg        <= len_next;
            addr_reg       <= addr_next;
            raddr_reg      <= raddr_next;
            wsum_reg       <= wsum_next;
            rsum_reg       <= rsum_next;
            rd_pending_reg <= rd_pending_next;
            error_reg      <= error_next;
            done_reg       <= done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        len_next        = len_reg;
        addr_next       = addr_reg;
        raddr_next      = raddr_reg;
        wsum_next       = wsum_reg;
        rsum_next       = rsum_reg;
        rd_pending_next = 1'b0;
        error_next      = error_reg;
        done_next       = 1'b0;
        in_ready        = 1'b0;
        ram_read_en     = 1'b0;
        ram_write_en    = 1'b0;
        ram_address     = '0;
        ram_write_data  = '0;

        // Read data arrives one cycle after the read was issued.
        if (rd_pending_reg) begin
            rsum_next = rsum_reg + ram_read_data;
        end

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    error_next = 1'b0;
                    if (length == '0) begin
                        done_next = 1'b1;
                    end else begin
                        len_next   = len_clamped;
                        addr_next  = '0;
                        raddr_next = '0;
                        wsum_next  = '0;
                        rsum_next  = '0;
                        state_next = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                in_ready       = 1'b1;
                ram_write_en   = in_valid;
                ram_address    = addr_reg;
                ram_write_data = in_data;
                if (in_valid) begin
                    wsum_next = wsum_reg + in_data;
                    if (last_wr) begin
                        state_next = (VERIFY != 0) ? S_READ : S_FINISH;
                    end else begin
                        addr_next = addr_reg + ADDR_WIDTH'(1);
                    end
                end
            end

            S_READ: begin
                ram_read_en     = 1'b1;
                ram_address     = raddr_reg;
                rd_pending_next = 1'b1;
                if (last_rd) begin
                    state_next = S_DRAIN;
                end else begin
                    raddr_next = raddr_reg + ADDR_WIDTH'(1);
                end
            end

            S_DRAIN: begin
                state_next = S_COMPARE;
            end

            S_COMPARE: begin
                done_next  = 1'b1;
                error_next = (rsum_reg != wsum_reg);
                state_next = S_IDLE;
            end

            S_FINISH: begin
                done_next  = 1'b1;
                error_next = 1'b0;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy  = (state_reg != S_IDLE);
    assign done  = done_reg;
    assign error = error_reg;

endmodule

// File: tb/tb_ram_loader.sv
// Randomized bench for ram_loader: behavioural RAM, stream driver, and a checksum/order
// reference computed directly from the byte list handed to each load.
module tb_ram_loader;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   length = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          ram_read_en;
    logic          ram_write_en;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_write_data;
    logic [DW-1:0] ram_read_data = '0;
    logic          busy;
    logic          done;
    logic          error;

    always #5 clk = ~clk;

    ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .VERIFY(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .length        (length),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ram_read_en   (ram_read_en),
        .ram_write_en  (ram_write_en),
        .ram_address   (ram_address),
        .ram_write_data(ram_write_data),
        .ram_read_data (ram_read_data),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    // Behavioural single-port RAM with optional bit-0 corruption on reads of address 2.
    logic [DW-1:0] mem [0:DEPTH-1];
    bit            flip_en = 1'b0;
    bit            conflict = 1'b0;
    int            cyc = 0;
    int            wr_addr_q[$];
    int            wr_data_q[$];
    int            rd_addr_q[$];
    int            rd_cyc_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_write_en) begin
            mem[ram_address] <= ram_write_data;
            wr_addr_q.push_back(int'(ram_address));
            wr_data_q.push_back(int'(ram_write_data));
        end
        if (ram_read_en) begin
            ram_read_data <= mem[ram_address] ^ ((flip_en && ram_address == 2) ? 8'h01 : 8'h00);
            rd_addr_q.push_back(int'(ram_address));
            rd_cyc_q.push_back(cyc);
        end
        if (ram_read_en && ram_write_en) conflict <= 1'b1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [7:0] stim [0:63];

    task automatic fill_random();
        for (int i = 0; i < 64; i++) stim[i] = 8'($urandom);
    endtask

    // One complete load; start_pulse_cyc injects a stray start at that cycle (0 = none).
    task automatic run_load(input int len_in, input bit corrupt, input logic [63:0] gap_mask,
                            input int start_pulse_cyc);
        int n, k, gaps, done_cyc, exp_done, bad_wr, bad_rd, bad_mem;
        bit ready_ok;
        logic [7:0] wsum, rsum;
        logic exp_err;

        n = (len_in > DEPTH) ? DEPTH : len_in;
        flip_en = corrupt;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); rd_cyc_q.delete();
        k = 0; gaps = 0; done_cyc = -1; ready_ok = 1'b1;

        @(negedge clk);
        start  = 1'b1;
        length = (AW + 1)'(len_in);
        for (int c = 1; c < 300; c++) begin
            @(negedge clk);
            start  = (c == start_pulse_cyc);
            length = 6'd7;
            if (c == 1) check("err_clr_on_start", {31'b0, error}, 32'd0);
            if (done) begin
                done_cyc = c;
                break;
            end
            if (k < n) begin
                if (!in_ready) ready_ok = 1'b0;
                if (c < 64 && gap_mask[c]) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    gaps++;
                end else begin
                    in_valid = 1'b1;
                    in_data  = stim[k];
                    k++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;

        // Reference: byte order, timing and checksum straight from the load rules.
        wsum = 8'd0;
        rsum = 8'd0;
        for (int i = 0; i < n; i++) begin
            wsum += stim[i];
            rsum += stim[i] ^ ((corrupt && i == 2) ? 8'h01 : 8'h00);
        end
        exp_err  = (n > 0) && (wsum != rsum);
        exp_done = (n == 0) ? 1 : 2 * n + 3 + gaps;

        bad_wr = (wr_addr_q.size() == n) ? 0 : 1000;
        for (int i = 0; i < n && i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] != i || wr_data_q[i] != int'(stim[i])) bad_wr++;
        bad_rd = (rd_addr_q.size() == n) ? 0 : 1000;
        for (int i = 0; i < n && i < rd_addr_q.size(); i++)
            if (rd_addr_q[i] != i || rd_cyc_q[i] != rd_cyc_q[0] + i) bad_rd++;
        bad_mem = 0;
        for (int i = 0; i < n; i++) if (mem[i] !== stim[i]) bad_mem++;

        check("done_cycle", done_cyc, exp_done);
        check("error", {31'b0, error}, {31'b0, exp_err});
        check("write_seq", bad_wr, 0);
        check("read_seq", bad_rd, 0);
        check("ram_contents", bad_mem, 0);
        if (n > 0) check("in_ready_in_load", {31'b0, ready_ok}, 32'd1);
        @(negedge clk);
        check("done_pulse_idle", {30'b0, done, busy}, 32'd0);
        $display("load len=%0d n=%0d gaps=%0d corrupt=%0b done@%0d error=%0b",
                 len_in, n, gaps, corrupt, done_cyc, error);
    endtask

    initial begin
        logic [63:0] mask;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Reset: two cycles low, then three idle cycles with nothing asserted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {17'b0, in_ready, ram_read_en, ram_write_en, ram_address, ram_write_data, busy, done, error},
              32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_quiet",
                  {17'b0, in_ready, ram_read_en, ram_write_en, ram_address, ram_write_data, busy, done, error},
                  32'd0);
        end

        // Basic load of four bytes, back-to-back.
        for (int i = 0; i < 64; i++) stim[i] = 8'h00;
        stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44;
        run_load(4, 1'b0, 64'd0, 0);

        // Same load with in_valid low in cycles 2 and 3.
        mask = 64'd0; mask[2] = 1'b1; mask[3] = 1'b1;
        run_load(4, 1'b0, mask, 0);

        // Corrupted read-back: error sticks until the next start clears it.
        run_load(4, 1'b1, 64'd0, 0);
        repeat (3) @(negedge clk);
        check("error_sticky", {31'b0, error}, 32'd1);
        run_load(0, 1'b0, 64'd0, 0);

        // Oversized length clamps to the full depth.
        fill_random();
        run_load(40, 1'b0, 64'd0, 0);

        // Stray start during LOAD is ignored.
        fill_random();
        run_load(6, 1'b0, 64'd0, 2);

        // Reset after two of four bytes, then a fresh load from address 0.
        @(negedge clk);
        start = 1'b1; length = 6'd4;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = stim[0];
        @(negedge clk);
        in_data = stim[1];
        @(negedge clk);
        in_data = stim[2];
        #1 rst_n = 1'b0;
        #1 check("abort_outputs", {29'b0, in_ready, ram_write_en, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        run_load(4, 1'b0, 64'd0, 0);

        // Randomized loads with random gaps and corruption.
        for (int t = 0; t < 6; t++) begin
            fill_random();
            mask = 64'd0;
            for (int c = 1; c < 64; c++) mask[c] = ($urandom_range(0, 3) == 0);
            run_load(int'($urandom_range(1, 40)), bit'($urandom_range(0, 1)), mask, 0);
        end

        check("rw_exclusive", {31'b0, conflict}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Initiator-side block for the 32x8 single-port RAM: drives the RAM's read_en/write_en/address/write_data and consumes its read_data.
- Accepts a byte stream over a valid/ready handshake and writes it to consecutive RAM addresses starting at 0.
- Optionally reads the region back and compares a mod-256 checksum against the written data.
- Used at boot to load program/data memory before the CPU core is released.

Parameters:
- ADDR_WIDTH, 5, RAM address width; depth DEPTH = 2**ADDR_WIDTH (local).
- DATA_WIDTH, 8, RAM/stream data width.
- VERIFY, 1, 1 = read-back checksum pass after load; 0 = finish directly after load.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- length  in  ADDR_WIDTH+1  byte count; 0 = empty load; values > DEPTH clamp to DEPTH.
- in_data  in  DATA_WIDTH  stream byte.
- in_valid  in  1  stream byte valid.
- in_ready  out  1  loader accepts byte this cycle.
- ram_read_en  out  1  to RAM read_en.
- ram_write_en  out  1  to RAM write_en.
- ram_address  out  ADDR_WIDTH  to RAM address.
- ram_write_data  out  DATA_WIDTH  to RAM write_data.
- ram_read_data  in  DATA_WIDTH  from RAM read_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  checksum mismatch; sticky until next accepted start.

Behaviour:
- Reset: async on rst_n low. State=IDLE; all outputs 0, including ram_address and ram_write_data. Checksums, counters and error cleared. Reset mid-operation aborts immediately; no RAM enable is asserted in the cycle reset deasserts.
- RAM contract: a write commits on the rising edge while write_en=1. Reads are registered: read_data for the address presented with read_en=1 in cycle k is valid in cycle k+1. read_en and write_en are never both 1.
- IDLE: in_ready=0, no RAM enables.
  - start=1 with length=0: done=1 next cycle, error=0, stay IDLE.
  - start=1 with length≠0: latch len=min(length,DEPTH), clear error, addr=0, wsum=0, rsum=0; go to LOAD.
- LOAD: in_ready=1.
  - Combinationally: ram_write_en = in_valid, ram_address = addr, ram_write_data = in_data.
  - On each handshake: wsum += in_data (mod 256), addr++.
  - in_valid gaps: no write, addr holds.
  - On the handshake at addr = len-1: go to READ (VERIFY=1) or FINISH (VERIFY=0). addr never wraps.
- READ: in_ready=0, ram_read_en=1, ram_address=raddr. raddr counts 0..len-1, one read per cycle. A registered flag marks that a read was issued last cycle; when set, rsum += ram_read_data. After issuing raddr = len-1, go to DRAIN.
- DRAIN: no enables. Accumulate the final read_data; go to COMPARE.
- COMPARE: done=1, error <= (rsum ≠ wsum); go to IDLE.
- FINISH: done=1, error=0; go to IDLE.
- Latency with in_valid held high: start cycle + N LOAD cycles; with VERIFY, + N READ cycles + DRAIN + COMPARE. done is asserted in cycle 2N+3 relative to the start cycle (cycle 0).
- start while busy is ignored. in_valid outside LOAD is ignored (in_ready=0). error is unchanged during a load and cleared only on an accepted start.

Test Plan:
- rst_n low for 2 cycles, then high -> all outputs 0, busy=0; no RAM enables for 3 idle cycles.
- VERIFY=1, length=4, stream 0x11,0x22,0x33,0x44 back-to-back into a behavioural RAM -> writes to addresses 0..3; reads 0..3 in the next 4 cycles; done pulse in cycle 11; error=0; RAM holds the bytes.
- Same load with in_valid low in cycles 2 and 3 -> in_ready stays 1, no write in gap cycles; addresses remain 0..3 in order; done is delayed by 2 cycles.
- RAM model flips bit 0 on reads of address 2 -> error=1 with the done pulse, held until the next start, which clears it.
- length=0 -> done the next cycle, no RAM enables. length=40 -> clamped to 32; writes to 0..31, no wrap; busy drops after COMPARE.
- start pulsed in LOAD is ignored. rst_n asserted after 2 of 4 bytes -> immediate IDLE, in_ready=0, ram_write_en=0; a new start reloads from address 0.
